// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: RUN/BUBBLE/FLUSH/HALT FSM driving per-stage holds.
// Optional stall watchdog enabled by defining PIPE_CTRL_TIMEOUT_EN.
module pipe_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id_i,
   input  logic        stallreq_ex_i,
   input  logic        load_use_i,
   input  logic        flush_req_i,
   input  logic [31:0] flush_pc_i,
   input  logic        halt_req_i,
   output logic [5:0]  stall_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        halted_o,
   output logic        stall_timeout_o
);

   typedef enum logic [1:0] {ST_RUN, ST_BUBBLE, ST_FLUSH, ST_HALT} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        pend_q, pend_d;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("pipe_ctrl: TIMEOUT_CYCLES out of range 1..65535");
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         pc_q    <= 32'h0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      case (state_q)
         ST_RUN, ST_BUBBLE: begin
            if (flush_req_i) begin
               state_d = ST_FLUSH;
               pc_d    = flush_pc_i;
            end else if (halt_req_i) begin
               state_d = ST_HALT;
            end else if (state_q == ST_RUN && !stallreq_ex_i && !stallreq_id_i && load_use_i) begin
               state_d = ST_BUBBLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (flush_req_i) begin
               state_d = ST_FLUSH;
               pc_d    = flush_pc_i;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            // A redirect seen while halted is remembered and taken on exit; the newest PC wins.
            if (flush_req_i) pc_d = flush_pc_i;
            if (!halt_req_i) begin
               pend_d  = 1'b0;
               state_d = (pend_q || flush_req_i) ? ST_FLUSH : ST_RUN;
            end else if (flush_req_i) begin
               pend_d = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      stall_o  = 6'b000000;
      flush_o  = 1'b0;
      halted_o = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (flush_req_i || halt_req_i) stall_o = 6'b000000;
            else if (stallreq_ex_i)        stall_o = 6'b001111;
            else if (stallreq_id_i || load_use_i) stall_o = 6'b000111;
         end
         ST_FLUSH: flush_o = 1'b1;
         ST_HALT: begin
            stall_o  = 6'b111111;
            halted_o = 1'b1;
         end
         default: ;
      endcase
   end

   assign new_pc_o = pc_q;

`ifdef PIPE_CTRL_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        timeout_q;
   logic        stalling;
   logic        hit;

   // The count includes the current stalled cycle, so the flag rises in the Nth stalled cycle.
   assign stalling = (state_q == ST_RUN) && (stall_o != 6'b000000);
   assign hit      = stalling && (({1'b0, cnt_q} + 17'd1) >= 17'(TIMEOUT_CYCLES));
   assign cnt_d    = !stalling ? 16'h0 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= 16'h0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_q | hit;
      end
   end

   assign stall_timeout_o = timeout_q | hit;
`else
   assign stall_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; timeout checks expect a flag only
// when PIPE_CTRL_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4 here).
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id_i, stallreq_ex_i, load_use_i, flush_req_i, halt_req_i;
   logic [31:0] flush_pc_i;
   logic [5:0]  stall_o;
   logic        flush_o, halted_o, stall_timeout_o;
   logic [31:0] new_pc_o;

   int n_cmp  = 0;
   int n_fail = 0;

`ifdef PIPE_CTRL_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   typedef struct {
      logic        id, ex, lu, fl, h;
      logic [31:0] pc;
      logic [5:0]  st;
      logic        fo, ho, to;
      logic [31:0] npc;
   } vec_t;

   vec_t vq[$];
   vec_t v;

   pipe_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .stallreq_id_i   (stallreq_id_i),
      .stallreq_ex_i   (stallreq_ex_i),
      .load_use_i      (load_use_i),
      .flush_req_i     (flush_req_i),
      .flush_pc_i      (flush_pc_i),
      .halt_req_i      (halt_req_i),
      .stall_o         (stall_o),
      .flush_o         (flush_o),
      .new_pc_o        (new_pc_o),
      .halted_o        (halted_o),
      .stall_timeout_o (stall_timeout_o)
   );

   always #5 clk = ~clk;

   // Inputs: id ex lu fl h pc ; expected: stall flush halted timeout new_pc(checked when flush)
   function automatic void add(input logic id, ex, lu, fl, h, input logic [31:0] pc,
                               input logic [5:0] st, input logic fo, ho, to,
                               input logic [31:0] npc);
      vec_t e;
      e.id = id; e.ex = ex; e.lu = lu; e.fl = fl; e.h = h; e.pc = pc;
      e.st = st; e.fo = fo; e.ho = ho; e.to = to; e.npc = npc;
      vq.push_back(e);
   endfunction

   task automatic drive(input logic id, ex, lu, fl, h, input logic [31:0] pc);
      stallreq_id_i = id; stallreq_ex_i = ex; load_use_i = lu;
      flush_req_i = fl; halt_req_i = h; flush_pc_i = pc;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 32'h0);
      #1;
      n_cmp++;
      if ({stall_o, flush_o, halted_o, stall_timeout_o, new_pc_o} !== {6'b0, 3'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_initial got stall=%b flush=%b halted=%b to=%b pc=%h required all zero",
                  stall_o, flush_o, halted_o, stall_timeout_o, new_pc_o);
      end
      drive(0, 1, 0, 1, 1, 32'h1234_5678);
      next_cycle();
      n_cmp++;
      if ({stall_o, flush_o, halted_o, new_pc_o} !== {6'b0, 2'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_hold got stall=%b flush=%b halted=%b pc=%h required zero",
                  stall_o, flush_o, halted_o, new_pc_o);
      end
      drive(0, 0, 0, 0, 0, 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({stall_o, flush_o, halted_o} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_idle cyc%0d got stall=%b flush=%b halted=%b required 0",
                     i, stall_o, flush_o, halted_o);
         end
         next_cycle();
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 0, 6'b001111, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
      for (int i = 0; vq.size() > 0; i++) begin
         v = vq.pop_front();
         drive(v.id, v.ex, v.lu, v.fl, v.h, v.pc);
         @(negedge clk);
         n_cmp++;
         if ({stall_o, flush_o, halted_o, stall_timeout_o} !== {v.st, v.fo, v.ho, v.to}) begin
            n_fail++;
            $display("FAIL stall cyc%0d got st=%b fl=%b h=%b to=%b required st=%b fl=%b h=%b to=%b",
                     i, stall_o, flush_o, halted_o, stall_timeout_o, v.st, v.fo, v.ho, v.to);
         end
         next_cycle();
      end
   endtask

   task automatic test_load_use();
      // single pulse, held pulse, stall during bubble, flush and halt from bubble
      add(0, 0, 1, 0, 0, 0, 6'b000111, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 6'b000111, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 6'b000111, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 32'h55, 6'b000000, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 6'b000000, 1, 0, 0, 32'h55);
      add(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
      add(0, 0, 1, 0, 0, 0, 6'b000111, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 6'b000000, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 6'b111111, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 6'b111111, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0);
      for (int i = 0; vq.size() > 0; i++) begin
         v = vq.pop_front();
         drive(v.id, v.ex, v.lu, v.fl, v.h, v.pc);
         @(negedge clk);
         n_cmp++;
         if ({stall_o, flush_o, halted_o, stall_timeout_o} !== {v.st, v.fo, v.ho, v.to}) begin
            n_fail++;
            $display("FAIL load_use cyc%0d got st=%b fl=%b h=%b to=%b required st=%b fl=%b h=%b to=%b",
                     i, stall_o, flush_o, halted_o, stall_timeout_o, v.st, v.fo, v.ho, v.to);
         end
         if (v.fo) begin
            n_cmp++;
            if (new_pc_o !== v.npc) begin
               n_fail++;
               $display("FAIL load_use_pc cyc%0d got %h required %h", i, new_pc_o, v.npc);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_flush();
      // back-to-back redirect, flush beats ex stall, flush beats halt
      add(0, 1, 0, 1, 0, 32'h40, 6'b000000, 0, 0, 0, 0);
      add(0, 0, 0, 1, 0, 32'h80, 6'b000000, 1, 0, 0, 32'h40);
      add(0, 0, 0, 0, 0, 0,      6'b000000, 1, 0, 0, 32'h80);
      add(0, 0, 0, 0, 0, 0,      6'b000000, 0, 0, 0, 0);
      add(0, 0, 0, 1, 1, 32'hA0, 6'b000000, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0,      6'b000000, 1, 0, 0, 32'hA0);
      add(0, 0, 0, 0, 1, 0,      6'b000000, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0,      6'b111111, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0,      6'b000000, 0, 0, 0, 0);
      for (int i = 0; vq.size() > 0; i++) begin
         v = vq.pop_front();
         drive(v.id, v.ex, v.lu, v.fl, v.h, v.pc);
         @(negedge clk);
         n_cmp++;
         if ({stall_o, flush_o, halted_o, stall_timeout_o} !== {v.st, v.fo, v.ho, v.to}) begin
            n_fail++;
            $display("FAIL flush cyc%0d got st=%b fl=%b h=%b to=%b required st=%b fl=%b h=%b to=%b",
                     i, stall_o, flush_o, halted_o, stall_timeout_o, v.st, v.fo, v.ho, v.to);
         end
         if (v.fo) begin
            n_cmp++;
            if (new_pc_o !== v.npc) begin
               n_fail++;
               $display("FAIL flush_pc cyc%0d got %h required %h", i, new_pc_o, v.npc);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_halt();
      // halt 5 cycles with redirect in cycle 2, then redirect at exit overriding pending PC
      add(0, 0, 0, 0, 1, 0,       6'b000000, 0, 0, 0, 0);
      add(0, 0, 0, 1, 1, 32'h100, 6'b111111, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 0,       6'b111111, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 0,       6'b111111, 0, 1, 0, 0);
      add(0, 0, 0, 0, 1, 0,       6'b111111, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0,       6'b111111, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0,       6'b000000, 1, 0, 0, 32'h100);
      add(0, 0, 0, 0, 0, 0,       6'b000000, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0,       6'b000000, 0, 0, 0, 0);
      add(0, 0, 0, 1, 1, 32'h200, 6'b111111, 0, 1, 0, 0);
      add(0, 1, 0, 1, 0, 32'h300, 6'b111111, 0, 1, 0, 0);
      add(0, 1, 0, 0, 0, 0,       6'b000000, 1, 0, 0, 32'h300);
      add(0, 0, 0, 0, 0, 0,       6'b000000, 0, 0, 0, 0);
      for (int i = 0; vq.size() > 0; i++) begin
         v = vq.pop_front();
         drive(v.id, v.ex, v.lu, v.fl, v.h, v.pc);
         @(negedge clk);
         n_cmp++;
         if ({stall_o, flush_o, halted_o, stall_timeout_o} !== {v.st, v.fo, v.ho, v.to}) begin
            n_fail++;
            $display("FAIL halt cyc%0d got st=%b fl=%b h=%b to=%b required st=%b fl=%b h=%b to=%b",
                     i, stall_o, flush_o, halted_o, stall_timeout_o, v.st, v.fo, v.ho, v.to);
         end
         if (v.fo) begin
            n_cmp++;
            if (new_pc_o !== v.npc) begin
               n_fail++;
               $display("FAIL halt_pc cyc%0d got %h required %h", i, new_pc_o, v.npc);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_abort();
      drive(0, 0, 0, 1, 0, 32'hDEAD_BEEF);
      next_cycle();
      drive(0, 0, 0, 0, 0, 32'h0);
      #1;
      n_cmp++;
      if (flush_o !== 1'b1 || new_pc_o !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL abort_flush_entry got flush=%b pc=%h required 1 deadbeef", flush_o, new_pc_o);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({flush_o, stall_o, new_pc_o} !== {7'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL abort_flush_rst got flush=%b stall=%b pc=%h required 0", flush_o, stall_o, new_pc_o);
      end
      next_cycle();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (flush_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_flush_after cyc%0d got flush=%b required 0", i, flush_o);
         end
         next_cycle();
      end
      drive(0, 0, 0, 0, 1, 32'h0);
      next_cycle();
      #1;
      n_cmp++;
      if (halted_o !== 1'b1 || stall_o !== 6'b111111) begin
         n_fail++;
         $display("FAIL abort_halt_entry got halted=%b stall=%b required 1 111111", halted_o, stall_o);
      end
      drive(0, 0, 0, 0, 0, 32'h0);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (halted_o !== 1'b0 || stall_o !== 6'b0) begin
         n_fail++;
         $display("FAIL abort_halt_rst got halted=%b stall=%b required 0", halted_o, stall_o);
      end
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({halted_o, flush_o, stall_o} !== 8'b0) begin
         n_fail++;
         $display("FAIL abort_halt_after got halted=%b flush=%b stall=%b required 0",
                  halted_o, flush_o, stall_o);
      end
      next_cycle();
   endtask

   task automatic test_timeout();
      add(1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 1'b0, 0);
      add(1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 1'b0, 0);
      add(1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, 1'b0, 0);
      add(1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, TO_EN, 0);
      add(1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, TO_EN, 0);
      add(1, 0, 0, 0, 0, 0, 6'b000111, 0, 0, TO_EN, 0);
      add(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, TO_EN, 0);
      add(0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, TO_EN, 0);
      for (int i = 0; vq.size() > 0; i++) begin
         v = vq.pop_front();
         drive(v.id, v.ex, v.lu, v.fl, v.h, v.pc);
         @(negedge clk);
         n_cmp++;
         if ({stall_o, flush_o, halted_o, stall_timeout_o} !== {v.st, v.fo, v.ho, v.to}) begin
            n_fail++;
            $display("FAIL timeout cyc%0d got st=%b fl=%b h=%b to=%b required st=%b fl=%b h=%b to=%b",
                     i, stall_o, flush_o, halted_o, stall_timeout_o, v.st, v.fo, v.ho, v.to);
         end
         next_cycle();
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (stall_timeout_o !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_rst got %b required 0", stall_timeout_o);
      end
      next_cycle();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stall();
      test_load_use();
      test_flush();
      test_halt();
      test_reset_abort();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
